// File: rtl/demux_lb_1xn_buf.sv
// 1-to-M demultiplexer with a single-word holding register per output lane.
// Words addressed beyond the last lane are accepted, dropped and counted.
module demux_lb_1xn_buf #(
   parameter int unsigned L = 16,
   parameter int unsigned N = 2,
   parameter int unsigned M = 4
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           flush,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [N-1:0]   in_addr,
   input  logic [L-1:0]   in_data,
   output logic [M-1:0]   out_valid,
   input  logic [M-1:0]   out_ready,
   output logic [M*L-1:0] out_data,
   output logic           drop_pulse,
   output logic [7:0]     drop_cnt,
   output logic           busy
);
   localparam logic [N:0] NumLanes = (N+1)'(M);

   logic [M-1:0]        valid_q, valid_d;
   logic [M-1:0][L-1:0] data_q, data_d;
   logic                drop_q, drop_d;
   logic [7:0]          cnt_q, cnt_d;
   logic                flush_eff;
   logic                in_range;
   logic                lane_free;
   logic                accept;

   // Reset outranks flush, so in_ready during reset reflects empty lanes only
   assign flush_eff = flush & rst_n;
   assign in_range  = ({1'b0, in_addr} < NumLanes);

   always_comb begin
      lane_free = 1'b0;
      for (int i = 0; i < M; i++) begin
         if (in_addr == N'(i)) begin
            lane_free = ~valid_q[i] | out_ready[i];
         end
      end
   end

   assign in_ready = ~flush_eff & (~in_range | lane_free);
   assign accept   = in_valid & in_ready;

   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      for (int i = 0; i < M; i++) begin
         if (valid_q[i] && out_ready[i]) begin
            valid_d[i] = 1'b0;
         end
         // A load after a drain in the same cycle keeps the lane full
         if (accept && in_range && (in_addr == N'(i))) begin
            valid_d[i] = 1'b1;
            data_d[i]  = in_data;
         end
      end
      if (flush) begin
         valid_d = '0;
      end
   end

   assign drop_d = accept & ~in_range;
   assign cnt_d  = (drop_d && (cnt_q != 8'hFF)) ? cnt_q + 8'd1 : cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= '0;
         data_q  <= '0;
         drop_q  <= 1'b0;
         cnt_q   <= 8'd0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
         drop_q  <= drop_d;
         cnt_q   <= cnt_d;
      end
   end

   assign out_valid  = valid_q;
   assign out_data   = data_q;
   assign drop_pulse = drop_q;
   assign drop_cnt   = cnt_q;
   assign busy       = |valid_q;

endmodule

// File: tb/tb_demux_lb_1xn_buf.sv
// Scoreboard bench: stimulus pushes expected lane words, a monitor pops them on drains.
// A second instance with three lanes exercises the drop path.
module tb_demux_lb_1xn_buf;
   localparam int unsigned L  = 16;
   localparam int unsigned N  = 2;
   localparam int unsigned M  = 4;
   localparam int unsigned DM = 3;

   logic           clk = 1'b0;
   logic           rst_n;
   logic           flush;
   logic           in_valid;
   logic           in_ready;
   logic [N-1:0]   in_addr;
   logic [L-1:0]   in_data;
   logic [M-1:0]   out_valid;
   logic [M-1:0]   out_ready;
   logic [M*L-1:0] out_data;
   logic           drop_pulse;
   logic [7:0]     drop_cnt;
   logic           busy;

   logic            d_flush;
   logic            d_in_valid;
   logic            d_in_ready;
   logic [N-1:0]    d_in_addr;
   logic [L-1:0]    d_in_data;
   logic [DM-1:0]   d_out_valid;
   logic [DM-1:0]   d_out_ready;
   logic [DM*L-1:0] d_out_data;
   logic            d_drop_pulse;
   logic [7:0]      d_drop_cnt;
   logic            d_busy;

   int tests = 0;
   int fails = 0;

   logic [L-1:0] exp_q [M][$];
   bit   [M-1:0] occ;
   int           mdl_cnt;
   bit           mdl_pulse;

   always #5 clk = ~clk;

   demux_lb_1xn_buf #(.L(L), .N(N), .M(M)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .flush      (flush),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_addr    (in_addr),
      .in_data    (in_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .drop_pulse (drop_pulse),
      .drop_cnt   (drop_cnt),
      .busy       (busy)
   );

   demux_lb_1xn_buf #(.L(L), .N(N), .M(DM)) dut_drop (
      .clk        (clk),
      .rst_n      (rst_n),
      .flush      (d_flush),
      .in_valid   (d_in_valid),
      .in_ready   (d_in_ready),
      .in_addr    (d_in_addr),
      .in_data    (d_in_data),
      .out_valid  (d_out_valid),
      .out_ready  (d_out_ready),
      .out_data   (d_out_data),
      .drop_pulse (d_drop_pulse),
      .drop_cnt   (d_drop_cnt),
      .busy       (d_busy)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Monitor: lane presence and data against the scoreboard, pop on each drain
   always @(negedge clk) begin
      if (rst_n) begin
         for (int i = 0; i < M; i++) begin
            check($sformatf("lane%0d_valid", i), 64'(out_valid[i]), 64'(exp_q[i].size() != 0));
            if (out_valid[i] && (exp_q[i].size() != 0)) begin
               check($sformatf("lane%0d_data", i), 64'(out_data[i*L +: L]), 64'(exp_q[i][0]));
               if (out_ready[i]) begin
                  void'(exp_q[i].pop_front());
               end
            end
         end
      end
   end

   task automatic drive(input logic v, input int a, input logic [L-1:0] d,
                        input logic [M-1:0] r, input logic f);
      in_valid  = v;
      in_addr   = N'(a);
      in_data   = d;
      out_ready = r;
      flush     = f;
   endtask

   // One clock: check control outputs against the model, then advance the model past the edge
   task automatic cycle();
      int           a;
      bit           rdy_exp;
      bit           acc;
      bit           drop;
      bit   [M-1:0] ord;
      logic [L-1:0] dat;
      @(negedge clk);
      a       = int'(in_addr);
      ord     = out_ready;
      dat     = in_data;
      rdy_exp = 1'b1;
      if (flush) rdy_exp = 1'b0;
      else if (a < M) rdy_exp = !occ[a] || ord[a];
      check("in_ready", 64'(in_ready), 64'(rdy_exp));
      check("busy", 64'(busy), 64'(|occ));
      check("drop_pulse", 64'(drop_pulse), 64'(mdl_pulse));
      check("drop_cnt", 64'(drop_cnt), 64'(mdl_cnt));
      acc  = in_valid && rdy_exp;
      drop = acc && (a >= M);
      @(posedge clk);
      #1;
      for (int i = 0; i < M; i++) begin
         if (flush) begin
            occ[i] = 1'b0;
            exp_q[i].delete();
         end else if (acc && a == i) begin
            occ[i] = 1'b1;
            exp_q[i].push_back(dat);
         end else if (occ[i] && ord[i]) begin
            occ[i] = 1'b0;
         end
      end
      mdl_pulse = drop;
      if (drop && mdl_cnt < 255) mdl_cnt++;
   endtask

   initial begin
      int exp_cnt;
      rst_n       = 1'b0;
      drive(1'b0, 0, '0, '0, 1'b0);
      d_flush     = 1'b0;
      d_in_valid  = 1'b0;
      d_in_addr   = '0;
      d_in_data   = '0;
      d_out_ready = '0;
      occ         = '0;
      mdl_cnt     = 0;
      mdl_pulse   = 1'b0;

      #2;
      check("rst_out_valid", 64'(out_valid), 64'(0));
      check("rst_out_data", 64'(out_data), 64'(0));
      check("rst_drop_pulse", 64'(drop_pulse), 64'(0));
      check("rst_drop_cnt", 64'(drop_cnt), 64'(0));
      check("rst_busy", 64'(busy), 64'(0));
      check("rst_in_ready", 64'(in_ready), 64'(1));
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Basic stall on lane 2
      drive(1'b1, 2, 16'h1111, 4'b0000, 1'b0);
      cycle();
      drive(1'b1, 2, 16'h2222, 4'b0000, 1'b0);
      cycle();
      check("basic_out_valid", 64'(out_valid), 64'(4'b0100));

      // Pass-through reload on lane 1
      drive(1'b1, 1, 16'hAAAA, 4'b0000, 1'b0);
      cycle();
      drive(1'b1, 1, 16'hBBBB, 4'b0010, 1'b0);
      cycle();
      check("pass_lane1_data", 64'(out_data[1*L +: L]), 64'(16'hBBBB));
      check("pass_lane1_valid", 64'(out_valid[1]), 64'(1));
      drive(1'b0, 0, '0, 4'b0110, 1'b0);
      cycle();

      // Independence: lane 0 stalled, lanes 1 and 3 back to back
      drive(1'b1, 0, 16'h0F0F, 4'b0000, 1'b0);
      cycle();
      drive(1'b1, 1, 16'h1234, 4'b0000, 1'b0);
      cycle();
      drive(1'b1, 3, 16'h5678, 4'b0000, 1'b0);
      cycle();
      drive(1'b0, 0, '0, 4'b0000, 1'b0);
      cycle();
      check("indep_out_valid", 64'(out_valid), 64'(4'b1011));

      // Flush with all lanes full
      drive(1'b1, 2, 16'h9999, 4'b0000, 1'b0);
      cycle();
      drive(1'b1, 2, 16'h7777, 4'b0000, 1'b1);
      cycle();
      check("flush_out_valid", 64'(out_valid), 64'(0));
      check("flush_drop_cnt", 64'(drop_cnt), 64'(0));

      // Asynchronous reset mid-cycle with lanes full
      for (int i = 0; i < M; i++) begin
         drive(1'b1, i, 16'hC000 + 16'(i), 4'b0000, 1'b0);
         cycle();
      end
      drive(1'b0, 0, '0, 4'b0000, 1'b0);
      #3;
      rst_n = 1'b0;
      #1;
      check("arst_out_valid", 64'(out_valid), 64'(0));
      check("arst_out_data", 64'(out_data), 64'(0));
      check("arst_busy", 64'(busy), 64'(0));
      check("arst_drop_cnt", 64'(drop_cnt), 64'(0));
      occ = '0;
      for (int i = 0; i < M; i++) exp_q[i].delete();
      @(negedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      cycle();

      // Randomised traffic
      for (int n = 0; n < 2000; n++) begin
         drive(($urandom_range(0, 3) != 0), int'($urandom_range(0, M - 1)), L'($urandom),
               M'($urandom), ($urandom_range(0, 31) == 0));
         cycle();
      end
      drive(1'b0, 0, '0, '1, 1'b0);
      cycle();
      cycle();
      for (int i = 0; i < M; i++) begin
         check($sformatf("drain_lane%0d_empty", i), 64'(exp_q[i].size()), 64'(0));
      end

      // Drop path on the three-lane instance
      d_in_valid = 1'b1;
      d_in_addr  = 2'd3;
      d_in_data  = 16'hDEAD;
      @(negedge clk);
      check("drop_in_ready", 64'(d_in_ready), 64'(1));
      @(posedge clk);
      #1;
      d_in_valid = 1'b0;
      @(negedge clk);
      check("drop_pulse_hi", 64'(d_drop_pulse), 64'(1));
      check("drop_cnt_one", 64'(d_drop_cnt), 64'(1));
      check("drop_no_lane", 64'(d_out_valid), 64'(0));
      @(posedge clk);
      #1;
      @(negedge clk);
      check("drop_pulse_lo", 64'(d_drop_pulse), 64'(0));
      @(posedge clk);
      #1;
      d_in_valid = 1'b1;
      d_in_addr  = 2'd2;
      d_in_data  = 16'h1234;
      @(negedge clk);
      check("d_lane2_ready", 64'(d_in_ready), 64'(1));
      @(posedge clk);
      #1;
      d_in_data = 16'h5678;
      @(negedge clk);
      check("d_lane2_stall", 64'(d_in_ready), 64'(0));
      check("d_lane2_valid", 64'(d_out_valid), 64'(3'b100));
      check("d_lane2_data", 64'(d_out_data[2*L +: L]), 64'(16'h1234));
      @(posedge clk);
      #1;
      d_in_addr = 2'd3;
      d_flush   = 1'b1;
      @(negedge clk);
      check("d_flush_ready", 64'(d_in_ready), 64'(0));
      @(posedge clk);
      #1;
      d_flush = 1'b0;
      @(negedge clk);
      check("d_flush_valid", 64'(d_out_valid), 64'(0));
      check("d_flush_cnt", 64'(d_drop_cnt), 64'(1));
      check("d_flush_pulse", 64'(d_drop_pulse), 64'(0));
      for (int k = 1; k <= 300; k++) begin
         @(posedge clk);
         #1;
         if (k == 300) d_in_valid = 1'b0;
         @(negedge clk);
         exp_cnt = (1 + k > 255) ? 255 : 1 + k;
         check("drop_sat_cnt", 64'(d_drop_cnt), 64'(exp_cnt));
      end
      @(posedge clk);
      #1;
      @(negedge clk);
      check("drop_final_cnt", 64'(d_drop_cnt), 64'(255));
      check("drop_final_pulse", 64'(d_drop_pulse), 64'(0));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
